// File: rtl/rst_seq.sv
// rst_seq: staged, synchronously released active-low resets with a soft-reset handshake (ack_o is combinational).
// Optional checks compile in under `RST_SEQ_ASSERT_EN; ports and cycle behaviour do not change with it.
module rst_seq #(
    parameter int NumRst       = 4,
    parameter int SyncStages   = 2,
    parameter int RstClkCycles = 16,
    parameter int GapCycles    = 8,
    parameter int CntWidth     = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    output logic                ack_o,
    output logic [NumRst-1:0]   rst_no,
    output logic                done_o,
    output logic [CntWidth-1:0] cycle_cnt_o
);
    localparam int MaxCycles = (RstClkCycles > GapCycles) ? RstClkCycles : GapCycles;
    localparam int TmrW      = $clog2(MaxCycles + 1);
    localparam int IdxW      = $clog2(NumRst + 1);

    localparam logic [TmrW-1:0] HoldLoad  = TmrW'(RstClkCycles - 1);
    localparam logic [TmrW-1:0] GapLoad   = TmrW'(GapCycles - 1);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumRst - 1);
    localparam bit              AllAtOnce = (NumRst == 1) || (GapCycles == 0);

    typedef enum logic [1:0] {SYNC, HOLD, RELEASE, DONE} state_e;

    state_e                state_q;
    logic [SyncStages-1:0] sync_q;
    logic [SyncStages-1:0] sync_d;
    logic [TmrW-1:0]       tmr_q;
    logic [IdxW-1:0]       idx_q;
    logic [NumRst-1:0]     rst_q;
    logic                  done_q;
    logic [CntWidth-1:0]   cnt_q;

    assign sync_d = {sync_q[SyncStages-2:0], 1'b1};

    // Counters are loaded with N-1 so the load edge itself counts as the first of N edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SYNC;
            sync_q  <= '0;
            tmr_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= sync_d;
            case (state_q)
                SYNC: begin
                    if (sync_d[SyncStages-1]) begin
                        tmr_q   <= HoldLoad;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (tmr_q == '0 && sync_q[SyncStages-1]) begin
                        if (AllAtOnce) begin
                            rst_q   <= '1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rst_q   <= NumRst'(1);
                            idx_q   <= IdxW'(1);
                            tmr_q   <= GapLoad;
                            state_q <= RELEASE;
                        end
                    end else if (tmr_q != '0) begin
                        tmr_q <= tmr_q - TmrW'(1);
                    end
                end
                RELEASE: begin
                    if (tmr_q == '0) begin
                        rst_q <= NumRst'({rst_q, 1'b1});
                        if (idx_q == LastIdx) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                            tmr_q <= GapLoad;
                        end
                    end else begin
                        tmr_q <= tmr_q - TmrW'(1);
                    end
                end
                DONE: begin
                    // Soft reset re-enters HOLD directly: the sync chain is already all ones.
                    if (req_i) begin
                        rst_q   <= '0;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        tmr_q   <= HoldLoad;
                        state_q <= HOLD;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign ack_o       = req_i && (state_q == DONE);
    assign rst_no      = rst_q;
    assign done_o      = done_q;
    assign cycle_cnt_o = cnt_q;

`ifdef RST_SEQ_ASSERT_EN
    if (SyncStages < 2) begin : g_chk_sync
        $fatal(1, "rst_seq: SyncStages must be at least 2");
    end
    if (RstClkCycles < 1) begin : g_chk_hold
        $fatal(1, "rst_seq: RstClkCycles must be at least 1");
    end
    if (NumRst < 1) begin : g_chk_num
        $fatal(1, "rst_seq: NumRst must be at least 1");
    end

    a_thermo: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((rst_no >> 1) & ~rst_no) == '0);
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !ack_o) |=> req_i);
    a_done_all: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_o == (&rst_no));
    a_cnt_mono: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (done_o && $past(done_o)) |-> (cycle_cnt_o >= $past(cycle_cnt_o)));
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: two instances (staggered release, and all-at-once with a 4-bit counter), schedule-based model and scoreboard.
module tb_rst_seq;
    localparam int     N     = 4;
    localparam int     S     = 2;
    localparam int     R     = 16;
    localparam int     GA    = 8;
    localparam int     GB    = 0;
    localparam longint CMAXA = 64'hFFFF_FFFF;
    localparam longint CMAXB = 15;

    localparam int S_RSTA = 0, S_DONEA = 1, S_CNTA = 2, S_ACKA = 3;
    localparam int S_RSTB = 4, S_DONEB = 5, S_CNTB = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        ack_a, done_a, ack_b, done_b;
    logic [3:0]  rst_a, rst_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    rst_seq #(.NumRst(N), .SyncStages(S), .RstClkCycles(R), .GapCycles(GA), .CntWidth(32)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .ack_o(ack_a),
        .rst_no(rst_a), .done_o(done_a), .cycle_cnt_o(cnt_a));

    rst_seq #(.NumRst(N), .SyncStages(S), .RstClkCycles(R), .GapCycles(GB), .CntWidth(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .ack_o(ack_b),
        .rst_no(rst_b), .done_o(done_b), .cycle_cnt_o(cnt_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  rst;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        int          ed;
        int          sel;
        logic [63:0] val;
    } dchk_t;

    exp_t  qa[$];
    exp_t  qb[$];
    dchk_t dq[$];
    int    ea = 0, ba = S, eb = 0, bb = S;
    int    checks = 0, errors = 0;
    bit    finishing = 1'b0, fin_done = 1'b0;
    bit    acc_a, acc_b;

    // Expected outputs after edge e of a sequence whose schedule starts at edge base.
    function automatic exp_t f_exp(int e, int base, int g, longint cmax);
        exp_t   x;
        longint de, el;
        x  = '0;
        de = longint'(base + R + (N - 1) * g);
        for (int k = 0; k < N; k++) x.rst[k] = (longint'(e) >= longint'(base + R + k * g));
        x.done = (longint'(e) >= de);
        if (x.done) begin
            el    = longint'(e) - de;
            x.cnt = 32'((el > cmax) ? cmax : el);
        end
        return x;
    endfunction

    function automatic logic [63:0] dut_val(int sel);
        case (sel)
            S_RSTA:  return 64'(rst_a);
            S_DONEA: return 64'(done_a);
            S_CNTA:  return 64'(cnt_a);
            S_ACKA:  return 64'(ack_a);
            S_RSTB:  return 64'(rst_b);
            S_DONEB: return 64'(done_b);
            S_CNTB:  return 64'(cnt_b);
            default: return '0;
        endcase
    endfunction

    function automatic string sel_name(int sel);
        case (sel)
            S_RSTA:  return "dir_rst_a";
            S_DONEA: return "dir_done_a";
            S_CNTA:  return "dir_cnt_a";
            S_ACKA:  return "dir_ack_a";
            S_RSTB:  return "dir_rst_b";
            S_DONEB: return "dir_done_b";
            S_CNTB:  return "dir_cnt_b";
            default: return "dir_unknown";
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic dexp(input int ed, input int sel, input longint val);
        dq.push_back('{ed, sel, 64'(val)});
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Reference models: a reset or an accepted request restarts the release schedule.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ea = 0; ba = S; qa.delete(); qa.push_back('0);
            eb = 0; bb = S; qb.delete(); qb.push_back('0);
        end else begin
            if (req_a && f_exp(ea, ba, GA, CMAXA).done) ba = ea + 1;
            ea = ea + 1;
            qa.push_back(f_exp(ea, ba, GA, CMAXA));
            if (req_b && f_exp(eb, bb, GB, CMAXB).done) bb = eb + 1;
            eb = eb + 1;
            qb.push_back(f_exp(eb, bb, GB, CMAXB));
        end
    end

    always begin
        exp_t  x;
        dchk_t d;
        @(negedge clk);
        if (qa.size() > 0) begin
            x = qa.pop_front();
            check("rst_a", 64'(rst_a), 64'(x.rst));
            check("done_a", 64'(done_a), 64'(x.done));
            check("cnt_a", 64'(cnt_a), 64'(x.cnt));
            check("ack_a", 64'(ack_a), 64'(x.done & req_a));
        end
        if (qb.size() > 0) begin
            x = qb.pop_front();
            check("rst_b", 64'(rst_b), 64'(x.rst));
            check("done_b", 64'(done_b), 64'(x.done));
            check("cnt_b", 64'(cnt_b), 64'(x.cnt[3:0]));
            check("ack_b", 64'(ack_b), 64'(x.done & req_b));
        end
        while (dq.size() > 0 && dq[0].ed <= ea) begin
            d = dq.pop_front();
            if (d.ed != ea) check("dir_edge_reached", 64'(ea), 64'(d.ed));
            else check(sel_name(d.sel), dut_val(d.sel), d.val);
        end
        if (finishing && !fin_done) begin
            check("dir_left", 64'(dq.size()), 64'(0));
            fin_done = 1'b1;
        end
    end

    initial begin
        // Default schedule, saturation on the 4-bit instance, then a soft reset at edge 60.
        hard_reset();
        dexp(17, S_RSTA, 0);  dexp(17, S_RSTB, 0);
        dexp(18, S_RSTA, 1);  dexp(18, S_RSTB, 15); dexp(18, S_DONEB, 1);
        dexp(25, S_RSTA, 1);  dexp(26, S_RSTA, 3);
        dexp(32, S_CNTB, 14); dexp(33, S_CNTB, 15);
        dexp(34, S_RSTA, 7);  dexp(41, S_DONEA, 0);
        dexp(42, S_RSTA, 15); dexp(42, S_DONEA, 1); dexp(47, S_CNTA, 5);
        dexp(58, S_CNTB, 15); dexp(59, S_ACKA, 1);  dexp(59, S_CNTA, 17);
        dexp(60, S_RSTA, 0);  dexp(60, S_CNTA, 0);  dexp(60, S_DONEA, 0);
        dexp(75, S_RSTA, 0);  dexp(76, S_RSTA, 1);
        dexp(99, S_DONEA, 0); dexp(100, S_DONEA, 1);
        for (int ed = 1; ed <= 105; ed++) begin
            @(posedge clk); #1;
            if (ed == 59) req_a = 1'b1;
            if (ed == 60) req_a = 1'b0;
        end

        // Short reset pulse mid-release, then a request held through the release phase.
        hard_reset();
        dexp(26, S_RSTA, 3);
        for (int ed = 1; ed <= 30; ed++) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        dexp(0, S_RSTA, 0);   dexp(0, S_DONEA, 0);
        dexp(17, S_RSTA, 0);  dexp(18, S_RSTA, 1);
        dexp(41, S_ACKA, 0);  dexp(42, S_ACKA, 1);  dexp(42, S_DONEA, 1);
        dexp(43, S_DONEA, 0); dexp(43, S_RSTA, 0);
        dexp(58, S_RSTA, 0);  dexp(59, S_RSTA, 1);
        for (int ed = 1; ed <= 65; ed++) begin
            @(posedge clk); #1;
            if (ed == 20) req_a = 1'b1;
            if (ed == 43) req_a = 1'b0;
        end

        // Random requests obeying the hold-until-ack rule, with occasional short reset pulses.
        hard_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc_a = req_a && ack_a;
            acc_b = req_b && ack_b;
            @(posedge clk); #1;
            if (acc_a) req_a = 1'b0;
            else if (!req_a && $urandom_range(0, 30) == 0) req_a = 1'b1;
            if (acc_b) req_b = 1'b0;
            else if (!req_b && $urandom_range(0, 30) == 0) req_b = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        finishing = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
